rotary_param_ctrl: RTL and testbench

//  Shares one rotary encoder among NUM_PARAMS synth parameter registers (tune, cutoff, ...).

---
 rtl/rotary_ctrl_pkg.sv | 20 ++
 rtl/rotary_param_ctrl_if.sv | 28 ++
 rtl/rotary_param_ctrl_press_classifier.sv | 65 ++++++
 rtl/rotary_param_ctrl.sv | 116 +++++++++++
 tb/tb_rotary_param_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rotary_ctrl_pkg.sv
// Shared types for the rotary parameter controller:
// press FSM state encoding and a constant clog2 helper.
package rotary_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TIMING = 2'd1,
        ST_HELD   = 2'd2
    } press_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rotary_param_ctrl_if.sv
// Encoder-side inputs and parameter-side outputs of the controller.
// master drives the encoder events; slave is the controller itself.
interface rotary_param_ctrl_if #(
    parameter int NUM_PARAMS = 4,
    parameter int W          = 15
);
    localparam int IW = rotary_ctrl_pkg::clog2(NUM_PARAMS);

    logic                  rot_event;
    logic                  rot_left;
    logic                  rot_press;
    logic                  coarse;
    logic [IW-1:0]         sel_idx;
    logic [W-1:0]          sel_value;
    logic [NUM_PARAMS*W-1:0] param_bus;
    logic                  upd_pulse;
    logic [IW-1:0]         upd_idx;

    modport master (
        output rot_event, rot_left, rot_press, coarse,
        input  sel_idx, sel_value, param_bus, upd_pulse, upd_idx
    );

    modport slave (
        input  rot_event, rot_left, rot_press, coarse,
        output sel_idx, sel_value, param_bus, upd_pulse, upd_idx
    );
endinterface

// File: rtl/rotary_param_ctrl_press_classifier.sv
// Push-switch classifier: turns the press level into a short-press
// pulse on release or a single long-press pulse after LONG_TICKS.
module press_classifier
    import rotary_ctrl_pkg::*;
#(
    parameter int LONG_TICKS = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rot_press,
    output logic short_pulse,
    output logic long_pulse,
    output logic idle
);
    localparam int TW = clog2(LONG_TICKS) + 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(LONG_TICKS - 1);

    press_state_e  state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;

    // Next state, timer and one-cycle classification pulses
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        short_pulse = 1'b0;
        long_pulse  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rot_press) begin
                    state_d = ST_TIMING;
                    timer_d = '0;
                end
            end
            ST_TIMING: begin
                if (!rot_press) begin
                    short_pulse = 1'b1;
                    state_d     = ST_IDLE;
                end else if (timer_q == LAST_TICK) begin
                    long_pulse = 1'b1;
                    state_d    = ST_HELD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (!rot_press) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and timer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign idle = (state_q == ST_IDLE);

endmodule

// File: rtl/rotary_param_ctrl.sv
// One rotary encoder shared across NUM_PARAMS parameter registers.
// Define ROTCTRL_WRAP_EN to wrap at the bounds instead of saturating.
module rotary_param_ctrl
    import rotary_ctrl_pkg::*;
#(
    parameter int NUM_PARAMS   = 4,
    parameter int W            = 15,
    parameter int MAX_VALUE    = 16383,
    parameter int DEFAULT_VAL  = 8192,
    parameter int COARSE_SHIFT = 5,
    parameter int LONG_TICKS   = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    rotary_param_ctrl_if.slave bus
);
    localparam int IW = clog2(NUM_PARAMS);
    localparam logic [W:0]    MAX_EXT  = (W+1)'(MAX_VALUE);
    localparam logic [W-1:0]  DEF      = W'(DEFAULT_VAL);
    localparam logic [IW-1:0] LAST_SEL = IW'(NUM_PARAMS - 1);

    logic short_pulse;
    logic long_pulse;
    logic fsm_idle;

    press_classifier #(
        .LONG_TICKS (LONG_TICKS)
    ) u_press (
        .clk         (clk),
        .rst_n       (rst_n),
        .rot_press   (bus.rot_press),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .idle        (fsm_idle)
    );

    logic [W-1:0]  params_q [NUM_PARAMS];
    logic [W-1:0]  params_d [NUM_PARAMS];
    logic [IW-1:0] sel_q, sel_d;
    logic [IW-1:0] upd_idx_q, upd_idx_d;
    logic          upd_pulse_q, upd_pulse_d;
    logic [W:0]    step;
    logic [W:0]    cur;
    logic [W:0]    nxt;

    // Stepped value of the selected register, one bit wider than W
    always_comb begin
        step = bus.coarse ? ((W+1)'(1) << COARSE_SHIFT) : (W+1)'(1);
        cur  = {1'b0, params_q[sel_q]};
        nxt  = cur;
`ifdef ROTCTRL_WRAP_EN
        if (bus.rot_left) begin
            if (cur == '0)       nxt = MAX_EXT;
            else if (cur < step) nxt = '0;
            else                 nxt = cur - step;
        end else begin
            if (cur == MAX_EXT)            nxt = '0;
            else if (cur + step > MAX_EXT) nxt = MAX_EXT;
            else                           nxt = cur + step;
        end
`else
        if (bus.rot_left) begin
            if (cur < step) nxt = '0;
            else            nxt = cur - step;
        end else begin
            if (cur + step > MAX_EXT) nxt = MAX_EXT;
            else                      nxt = cur + step;
        end
`endif
    end

    // Register-file writes, selection advance and update strobe
    always_comb begin
        params_d    = params_q;
        sel_d       = sel_q;
        upd_pulse_d = 1'b0;
        upd_idx_d   = upd_idx_q;
        if (long_pulse) begin
            params_d[sel_q] = DEF;
            upd_pulse_d     = 1'b1;
            upd_idx_d       = sel_q;
        end else if (bus.rot_event && fsm_idle && (nxt != cur)) begin
            params_d[sel_q] = nxt[W-1:0];
            upd_pulse_d     = 1'b1;
            upd_idx_d       = sel_q;
        end
        if (short_pulse) begin
            sel_d = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PARAMS; i++) params_q[i] <= DEF;
            sel_q       <= '0;
            upd_idx_q   <= '0;
            upd_pulse_q <= 1'b0;
        end else begin
            params_q    <= params_d;
            sel_q       <= sel_d;
            upd_idx_q   <= upd_idx_d;
            upd_pulse_q <= upd_pulse_d;
        end
    end

    assign bus.sel_idx   = sel_q;
    assign bus.sel_value = params_q[sel_q];
    assign bus.upd_pulse = upd_pulse_q;
    assign bus.upd_idx   = upd_idx_q;

    for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_bus
        assign bus.param_bus[g*W +: W] = params_q[g];
    end

endmodule

// File: tb/tb_rotary_param_ctrl.sv
// Scoreboard bench for rotary_param_ctrl (LONG_TICKS=100).
// Build with ROTCTRL_WRAP_EN to check the wrapping variant.
module tb_rotary_param_ctrl;
    localparam int NP   = 4;
    localparam int W    = 15;
    localparam int MAXV = 16383;
    localparam int DEF  = 8192;
    localparam int LT   = 100;

    typedef struct {
        int idx;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   upd_cyc = 0;
    int   m [NP];
    int   msel;
    exp_t sbq [$];

    rotary_param_ctrl_if #(.NUM_PARAMS(NP), .W(W)) bus ();

    rotary_param_ctrl #(
        .NUM_PARAMS   (NP),
        .W            (W),
        .MAX_VALUE    (MAXV),
        .DEFAULT_VAL  (DEF),
        .COARSE_SHIFT (5),
        .LONG_TICKS   (LT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int model_next(int v, bit left, bit crs);
        int s;
        s = crs ? 32 : 1;
        if (left) begin
`ifdef ROTCTRL_WRAP_EN
            if (v == 0) return MAXV;
`endif
            return (v < s) ? 0 : v - s;
        end
`ifdef ROTCTRL_WRAP_EN
        if (v == MAXV) return 0;
`endif
        return (v + s > MAXV) ? MAXV : v + s;
    endfunction

    // Scoreboard: every update strobe must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && bus.upd_pulse) begin
            upd_cyc = cyc;
            if (sbq.size() == 0) begin
                chk("spurious_upd", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("upd_idx", 32'(bus.upd_idx), 32'(e.idx));
                chk("upd_val", 32'(bus.param_bus[int'(bus.upd_idx)*W +: W]),
                    32'(e.val));
            end
        end
    end

    task automatic check_all(input string tag);
        for (int i = 0; i < NP; i++) begin
            chk($sformatf("%s_p%0d", tag, i),
                32'(bus.param_bus[i*W +: W]), 32'(m[i]));
        end
        chk({tag, "_sel"}, 32'(bus.sel_idx), 32'(msel));
        chk({tag, "_selv"}, 32'(bus.sel_value), 32'(m[msel]));
    endtask

    task automatic do_step(input bit left, input bit crs);
        int nv;
        @(negedge clk);
        bus.rot_event = 1'b1;
        bus.rot_left  = left;
        bus.coarse    = crs;
        nv = model_next(m[msel], left, crs);
        if (nv != m[msel]) begin
            m[msel] = nv;
            sbq.push_back('{msel, nv});
        end
        @(negedge clk);
        bus.rot_event = 1'b0;
    endtask

    task automatic step_n(input bit left, input bit crs, input int n);
        for (int i = 0; i < n; i++) do_step(left, crs);
    endtask

    task automatic do_press(input int n, input bit long_exp);
        int c0;
        @(negedge clk);
        c0 = cyc;
        bus.rot_press = 1'b1;
        if (long_exp) begin
            m[msel] = DEF;
            sbq.push_back('{msel, DEF});
        end
        repeat (n) @(negedge clk);
        bus.rot_press = 1'b0;
        if (!long_exp) msel = (msel + 1) % NP;
        repeat (3) @(negedge clk);
        if (long_exp) chk("long_latency", 32'(upd_cyc - c0), 32'd101);
    endtask

    initial begin
        bus.rot_event = 1'b0;
        bus.rot_left  = 1'b0;
        bus.rot_press = 1'b0;
        bus.coarse    = 1'b0;
        for (int i = 0; i < NP; i++) m[i] = DEF;
        msel = 0;
        repeat (3) @(negedge clk);
        check_all("reset");
        chk("reset_upd", 32'(bus.upd_pulse), 32'd0);
        chk("reset_updidx", 32'(bus.upd_idx), 32'd0);
        rst_n = 1'b1;

        // 1: three fine increments on param0
        step_n(1'b0, 1'b0, 3);
        @(negedge clk);
        chk("t1_p0", 32'(bus.param_bus[0 +: W]), 32'd8195);
        check_all("t1");

        // 2: short presses walk and wrap the selection
        do_press(10, 1'b0);
        chk("t2_sel1", 32'(bus.sel_idx), 32'd1);
        do_press(10, 1'b0);
        do_press(10, 1'b0);
        do_press(10, 1'b0);
        chk("t2_sel0", 32'(bus.sel_idx), 32'd0);

        // 3: coarse decrement toward the lower bound on param2
        do_press(10, 1'b0);
        do_press(10, 1'b0);
        step_n(1'b1, 1'b1, 254);
        step_n(1'b1, 1'b0, 24);
        @(negedge clk);
        chk("t3_40", 32'(bus.sel_value), 32'd40);
        do_step(1'b1, 1'b1);
        @(negedge clk);
        chk("t3_8", 32'(bus.sel_value), 32'd8);
        do_step(1'b1, 1'b1);
        @(negedge clk);
        chk("t3_0", 32'(bus.sel_value), 32'd0);
        do_step(1'b1, 1'b1);
        @(negedge clk);
`ifdef ROTCTRL_WRAP_EN
        chk("t3_wrap", 32'(bus.sel_value), 32'd16383);
`else
        chk("t3_sat", 32'(bus.sel_value), 32'd0);
`endif
        check_all("t3");

        // 4: upper saturation then long-press restore on param1
        do_press(10, 1'b0);
        do_press(10, 1'b0);
        do_press(10, 1'b0);
        chk("t4_sel", 32'(bus.sel_idx), 32'd1);
        step_n(1'b0, 1'b1, 255);
        step_n(1'b0, 1'b0, 28);
        @(negedge clk);
        chk("t4_16380", 32'(bus.sel_value), 32'd16380);
        do_step(1'b0, 1'b1);
        @(negedge clk);
        chk("t4_max", 32'(bus.sel_value), 32'd16383);
        do_press(150, 1'b1);
        chk("t4_def", 32'(bus.param_bus[W +: W]), 32'd8192);
        check_all("t4");

        // 5: turning while held and on the release cycle is ignored
        step_n(1'b0, 1'b0, 5);
        @(negedge clk);
        bus.rot_press = 1'b1;
        m[msel] = DEF;
        sbq.push_back('{msel, DEF});
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            bus.rot_event = (i % 7 == 3);
            bus.rot_left  = i[0];
        end
        @(negedge clk);
        bus.rot_press = 1'b0;
        bus.rot_event = 1'b1;
        @(negedge clk);
        bus.rot_event = 1'b0;
        repeat (3) @(negedge clk);
        check_all("t5_held");
        @(negedge clk);
        bus.rot_press = 1'b1;
        repeat (10) @(negedge clk);
        bus.rot_press = 1'b0;
        bus.rot_event = 1'b1;
        bus.rot_left  = 1'b0;
        msel = (msel + 1) % NP;
        @(negedge clk);
        bus.rot_event = 1'b0;
        repeat (3) @(negedge clk);
        check_all("t5_rel");

        // 6: reset in the middle of a press drops everything
        do_step(1'b0, 1'b1);
        @(negedge clk);
        bus.rot_press = 1'b1;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        bus.rot_press = 1'b0;
        for (int i = 0; i < NP; i++) m[i] = DEF;
        msel = 0;
        sbq.delete();
        @(negedge clk);
        check_all("t6_rst");
        chk("t6_upd", 32'(bus.upd_pulse), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        check_all("t6_after");

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
